// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit scheduler state type.
package uart_pkg;

  localparam int unsigned BAUD_DIV_9600 = 5208;
  localparam int unsigned UART_DATA_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one byte serializer among N_REQ requesters,
// with busy tracking, start timeout and an inter-frame idle gap.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter  int unsigned N_REQ      = 4,
  parameter  int unsigned GAP_CYCLES = BAUD_DIV_9600,
  parameter  int unsigned BUSY_TO    = 65535,
  localparam int unsigned IDX_W      = $clog2(N_REQ)
) (
  input  logic                         clk_50M,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req,
  input  logic [UART_DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]             ack,
  output logic                         tx_start,
  output logic [UART_DATA_W-1:0]       tx_data,
  input  logic                         tx_busy,
  output logic [IDX_W-1:0]             grant_id,
  output logic                         active,
  output logic                         err_timeout
);

  // The counter starts one cycle after tx_start, so firing at BUSY_TO-2
  // places the err_timeout pulse exactly BUSY_TO cycles after tx_start.
  localparam logic [15:0] TO_LAST  = 16'(BUSY_TO - 2);
  localparam logic [12:0] GAP_LOAD = 13'(GAP_CYCLES - 1);

  sched_state_t     state;
  logic [IDX_W-1:0] ptr;
  logic [15:0]      to_cnt;
  logic [12:0]      gap_cnt;
  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      ack         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      ack         <= '0;
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (arb_any) begin
            tx_data  <= req_data[arb_idx*UART_DATA_W +: UART_DATA_W];
            grant_id <= arb_idx;
            ack      <= arb_grant;
            active   <= 1'b1;
            state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          ptr      <= (32'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
          tx_start <= 1'b1;
          state    <= S_LAUNCH;
        end
        S_LAUNCH: begin
          to_cnt <= '0;
          state  <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (to_cnt >= TO_LAST) begin
            err_timeout <= 1'b1;
            active      <= 1'b0;
            state       <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            gap_cnt <= GAP_LOAD;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            active <= 1'b0;
            state  <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched against a transaction-level scheduler and serializer model.
module tb_uart_tx_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned G  = 20;
  localparam int unsigned TO = 40;

  logic           clk_50M  = 1'b0;
  logic           reset    = 1'b1;
  logic [N-1:0]   req      = '0;
  logic [8*N-1:0] req_data = '0;
  logic           tx_busy  = 1'b0;
  logic [N-1:0]   ack;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic [1:0]     grant_id;
  logic           active;
  logic           err_timeout;

  always #10 clk_50M = ~clk_50M;

  uart_tx_sched #(
    .N_REQ      (N),
    .GAP_CYCLES (G),
    .BUSY_TO    (TO)
  ) dut (
    .clk_50M     (clk_50M),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .err_timeout (err_timeout)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: who may be served, when, and what the serializer should see
  int         cyc        = 0;
  int         m_ptr      = 0;
  bit         m_open     = 1'b0;
  int         m_earliest = 0;
  logic [7:0] m_byte     = '0;
  int         m_start_exp = -1;
  int         m_to_exp   = -1;
  bit         ser_never  = 1'b0;
  int         ser_phase  = 0;
  int         ser_cnt    = 0;
  int         drop_step  = -1;
  int         last_ack_step = -1;
  bit         auto_drop  = 1'b1;
  int         n_ack      = 0;
  int         n_err      = 0;
  int         ack_log[$];
  logic [7:0] byte_log[$];

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic step();
    int         w;
    logic [N-1:0] exp_ack;
    bit         exp_start;
    bit         exp_err;
    @(posedge clk_50M);
    #1;
    cyc++;
    exp_ack = '0;
    w = -1;
    if (!m_open && cyc >= m_earliest) w = rr_pick(req, m_ptr);
    if (w >= 0) exp_ack[w] = 1'b1;
    if (ack !== '0 || exp_ack !== '0) check_eq("ack", ack, exp_ack);
    if (w >= 0) begin
      check_eq("grant_id", grant_id, w);
      m_open = 1'b1;
      m_ptr = (w + 1) % N;
      m_byte = req_data[8*w +: 8];
      m_start_exp = cyc + 1;
      last_ack_step = cyc;
      n_ack++;
      ack_log.push_back(w);
      if (auto_drop) req[w] = 1'b0;
    end
    case (ser_phase)
      1: begin
        ser_cnt--;
        if (ser_cnt == 0) begin
          tx_busy = 1'b1;
          ser_phase = 2;
          ser_cnt = $urandom_range(20, 3);
        end
      end
      2: begin
        ser_cnt--;
        if (ser_cnt == 0) begin
          tx_busy = 1'b0;
          ser_phase = 0;
          drop_step = cyc;
          m_open = 1'b0;
          m_earliest = cyc + G + 2;
        end
      end
      default: ;
    endcase
    exp_start = (cyc == m_start_exp);
    if (tx_start || exp_start) check_eq("tx_start", tx_start, exp_start);
    if (exp_start) begin
      check_eq("tx_data", tx_data, m_byte);
      byte_log.push_back(tx_data);
      if (ser_never) m_to_exp = cyc + TO;
      else begin
        ser_phase = 1;
        ser_cnt = $urandom_range(3, 1);
      end
    end
    exp_err = (cyc == m_to_exp);
    if (err_timeout || exp_err) check_eq("err_timeout", err_timeout, exp_err);
    if (err_timeout) n_err++;
    if (exp_err) begin
      m_open = 1'b0;
      m_earliest = cyc + 1;
      m_to_exp = -1;
    end
    check_eq("active", active, (m_open || cyc < m_earliest - 1));
  endtask

  task automatic run_until_ack(input int target, input string tag);
    for (int k = 0; k < 600 && n_ack < target; k++) step();
    check_eq({tag, "_acks"}, n_ack, target);
  endtask

  task automatic run_until_idle(input string tag);
    for (int k = 0; k < 600 && (m_open || cyc < m_earliest); k++) step();
    check_eq({tag, "_idle"}, active, 0);
  endtask

  task automatic set_req(input int i, input logic [7:0] b);
    req_data[8*i +: 8] = b;
    req[i] = 1'b1;
  endtask

  initial begin
    int base;
    int req_step;
    int nb;
    int sb;

    #3 reset = 1'b0;
    #2;
    check_eq("rst_ack", ack, 0);
    check_eq("rst_tx_start", tx_start, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_active", active, 0);
    check_eq("rst_err", err_timeout, 0);
    @(posedge clk_50M);
    @(posedge clk_50M);
    #1;
    reset = 1'b1;
    cyc = 0;
    m_earliest = 1;

    // Single requester, latency, then a pending request held off by the gap
    set_req(2, 8'hA5);
    req_step = cyc;
    run_until_ack(1, "t1a");
    check_eq("t1_lat", last_ack_step, req_step + 1);
    set_req(3, 8'h5A);
    run_until_ack(2, "t1b");
    check_eq("t1_gap", last_ack_step - drop_step, G + 2);
    run_until_idle("t1");
    tx_busy = 1'b1;
    repeat (3) step();
    tx_busy = 1'b0;
    repeat (3) step();

    // All four held: strict rotation starting at requester 0
    auto_drop = 1'b0;
    ack_log.delete();
    byte_log.delete();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = '1;
    base = n_ack;
    run_until_ack(base + 5, "t2");
    req = '0;
    auto_drop = 1'b1;
    run_until_idle("t2");
    check_eq("t2_nacks", ack_log.size(), 5);
    check_eq("t2_nbytes", byte_log.size(), 5);
    if (ack_log.size() == 5 && byte_log.size() == 5) begin
      check_eq("t2_ack0", ack_log[0], 0);
      check_eq("t2_ack1", ack_log[1], 1);
      check_eq("t2_ack2", ack_log[2], 2);
      check_eq("t2_ack3", ack_log[3], 3);
      check_eq("t2_ack4", ack_log[4], 0);
      check_eq("t2_b0", byte_log[0], 8'h11);
      check_eq("t2_b1", byte_log[1], 8'h22);
      check_eq("t2_b2", byte_log[2], 8'h33);
      check_eq("t2_b3", byte_log[3], 8'h44);
      check_eq("t2_b4", byte_log[4], 8'h11);
    end

    // Pointer at 1: requesters 3 and 0 are served 3 first
    ack_log.delete();
    set_req(0, 8'hC0);
    set_req(3, 8'hC3);
    base = n_ack;
    run_until_ack(base + 2, "t3");
    run_until_idle("t3");
    check_eq("t3_n", ack_log.size(), 2);
    if (ack_log.size() == 2) begin
      check_eq("t3_first", ack_log[0], 3);
      check_eq("t3_second", ack_log[1], 0);
    end

    // Serializer never goes busy: one timeout, then normal service
    ser_never = 1'b1;
    nb = n_err;
    set_req(1, 8'h7E);
    run_until_ack(n_ack + 1, "t4a");
    run_until_idle("t4a");
    check_eq("t4_nerr", n_err, nb + 1);
    ser_never = 1'b0;
    set_req(2, 8'h3C);
    run_until_ack(n_ack + 1, "t4b");
    run_until_idle("t4b");

    // Reset while the frame is in flight
    set_req(1, 8'h96);
    run_until_ack(n_ack + 1, "t5a");
    for (int k = 0; k < 50 && ser_phase != 2; k++) step();
    check_eq("t5_busy", tx_busy, 1);
    step();
    check_eq("t5_active", active, 1);
    reset = 1'b0;
    #1;
    check_eq("t5_ack", ack, 0);
    check_eq("t5_tx_start", tx_start, 0);
    check_eq("t5_tx_data", tx_data, 0);
    check_eq("t5_grant_id", grant_id, 0);
    check_eq("t5_active0", active, 0);
    check_eq("t5_err", err_timeout, 0);
    tx_busy = 1'b0;
    ser_phase = 0;
    m_open = 1'b0;
    m_ptr = 0;
    m_start_exp = -1;
    m_to_exp = -1;
    req = '0;
    @(posedge clk_50M);
    @(posedge clk_50M);
    #1;
    cyc += 2;
    reset = 1'b1;
    m_earliest = cyc + 1;
    set_req(2, 8'hB2);
    set_req(3, 8'hB3);
    run_until_ack(n_ack + 1, "t5b");
    check_eq("t5_winner", ack_log[$], 2);
    run_until_ack(n_ack + 1, "t5c");
    run_until_idle("t5");

    // One-cycle request during the gap is never served
    set_req(0, 8'hE0);
    run_until_ack(n_ack + 1, "t6a");
    for (int k = 0; k < 100 && (m_open || ser_phase != 0); k++) step();
    repeat (3) step();
    nb = n_ack;
    sb = byte_log.size();
    set_req(1, 8'hE1);
    step();
    req[1] = 1'b0;
    run_until_idle("t6");
    repeat (10) step();
    check_eq("t6_no_ack", n_ack, nb);
    check_eq("t6_no_start", byte_log.size(), sb);

    // Random traffic with withdrawals
    for (int s = 0; s < 800; s++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(7, 0) == 0) set_req(i, 8'($urandom));
        else if (req[i] && $urandom_range(39, 0) == 0) req[i] = 1'b0;
      end
      step();
    end
    req = '0;
    run_until_idle("rnd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
